rr_arb_mux: RTL and testbench

Parametrised, registered N-to-1 multiplexer with valid/ready handshaking and round-robin arbitration. It is the successor to the quad 4:1 mux building block. Instead of a caller-driven static select, it selects among NCH requesting channels of WIDTH bits each, fairly, and holds the result in an output register until the consumer accepts it. It sits between multiple producers (e.g. requesters sharing one bus or functional unit) and a single consumer.

---
 rtl/rr_arb_mux.sv | 121 ++++++++++++
 tb/tb_rr_arb_mux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered NCH-to-1 mux with valid/ready handshake and round-robin grant.
// Optional static-select override ports are added when RR_ARB_MUX_FORCE_SEL_EN is defined.
module rr_arb_mux #(
  parameter int WIDTH = 4,
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
`ifdef RR_ARB_MUX_FORCE_SEL_EN
  ,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel
`endif
);

  logic [WIDTH-1:0] chan_data [NCH];
  logic [SELW-1:0]  scan_idx [NCH];
  logic [NCH-1:0]   scan_req;

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SELW-1:0]  out_ch_reg, out_ch_next;
  logic [SELW-1:0]  ptr_reg, ptr_next;

  logic             load;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic             grant_forced;

  assign load = !out_valid_reg || out_ready;

  // scan_idx[k] is the channel visited k-th when scanning from ptr, wrapping at NCH.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic [SELW:0] sum;
    assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    assign sum           = {1'b0, ptr_reg} + (SELW+1)'(gi);
    assign scan_idx[gi]  = (sum >= (SELW+1)'(NCH)) ? SELW'(sum - (SELW+1)'(NCH))
                                                   : SELW'(sum);
    assign scan_req[gi]  = in_valid[scan_idx[gi]];
  end

  // Walk offsets high to low so the lowest requesting offset wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (scan_req[k]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx[k];
      end
    end
  end

`ifdef RR_ARB_MUX_FORCE_SEL_EN
  always_comb begin
    grant_forced = force_en;
    grant_found  = rr_found;
    grant_idx    = rr_idx;
    if (force_en) begin
      grant_found = ({1'b0, force_sel} < (SELW+1)'(NCH)) && in_valid[force_sel];
      grant_idx   = force_sel;
    end
  end
`else
  assign grant_forced = 1'b0;
  assign grant_found  = rr_found;
  assign grant_idx    = rr_idx;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign in_ready[gi] = !rst && load && grant_found && (grant_idx == SELW'(gi));
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    ptr_next       = ptr_reg;
    if (load) begin
      if (grant_found) begin
        out_valid_next = 1'b1;
        out_data_next  = chan_data[grant_idx];
        out_ch_next    = grant_idx;
        if (!grant_forced) begin
          ptr_next = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: NCH=4 and NCH=3 instances share stimulus; a queue-free
// behavioural model is checked every cycle, plus directed literal expectations.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic        out_ready;
`ifdef RR_ARB_MUX_FORCE_SEL_EN
  logic        force_en;
  logic [1:0]  force_sel;
`endif

  logic [3:0] rdy4;
  logic       ov4;
  logic [3:0] od4;
  logic [1:0] och4;
  logic [2:0] rdy3;
  logic       ov3;
  logic [3:0] od3;
  logic [1:0] och3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(4), .NCH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy4), .out_valid(ov4), .out_data(od4), .out_ch(och4),
    .out_ready(out_ready)
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    , .force_en(force_en), .force_sel(force_sel)
`endif
  );

  rr_arb_mux #(.WIDTH(4), .NCH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2:0]), .in_data(in_data[11:0]),
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_ch(och3),
    .out_ready(out_ready)
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    , .force_en(force_en), .force_sel(force_sel)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state per instance: index 0 is NCH=4, index 1 is NCH=3.
  int m_ptr [2];
  int m_ov  [2];
  int m_od  [2];
  int m_och [2];
  bit started = 1'b0;

  // Which channel the rules say is granted right now, given the model pointer.
  function automatic void pick(input int n, input int ptr,
                               output bit found, output int ch, output bit forced);
    found  = 1'b0;
    ch     = 0;
    forced = 1'b0;
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    if (force_en) begin
      forced = 1'b1;
      ch     = int'(force_sel);
      found  = (ch < n) && (in_valid[ch] == 1'b1);
      return;
    end
`endif
    for (int k = 0; k < n; k++) begin
      if (in_valid[(ptr + k) % n]) begin
        found = 1'b1;
        ch    = (ptr + k) % n;
        return;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_ptr[i] = 0; m_ov[i] = 0; m_od[i] = 0; m_och[i] = 0;
      end
    end else if (started) begin
      for (int i = 0; i < 2; i++) begin
        int  n;
        int  c;
        bit  f;
        bit  fz;
        n = (i == 0) ? 4 : 3;
        if (m_ov[i] == 0 || out_ready) begin
          pick(n, m_ptr[i], f, c, fz);
          if (f) begin
            m_ov[i]  = 1;
            m_od[i]  = int'((in_data >> (4 * c)) & 16'hF);
            m_och[i] = c;
            if (!fz) m_ptr[i] = (c + 1) % n;
          end else begin
            m_ov[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int          n;
        int          c;
        bit          f;
        bit          fz;
        logic [31:0] exp_rdy;
        n = (i == 0) ? 4 : 3;
        exp_rdy = 0;
        if (!rst && (m_ov[i] == 0 || out_ready)) begin
          pick(n, m_ptr[i], f, c, fz);
          if (f) exp_rdy = 32'd1 << c;
        end
        check($sformatf("model_in_ready_n%0d", n), (i == 0) ? {28'd0, rdy4} : {29'd0, rdy3}, exp_rdy);
        check($sformatf("model_out_valid_n%0d", n), (i == 0) ? {31'd0, ov4} : {31'd0, ov3}, m_ov[i]);
        check($sformatf("model_out_data_n%0d", n), (i == 0) ? {28'd0, od4} : {28'd0, od3}, m_od[i]);
        check($sformatf("model_out_ch_n%0d", n), (i == 0) ? {30'd0, och4} : {30'd0, och3}, m_och[i]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rr_d  [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
  logic [1:0] n3_ch [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    rst = 1'b1; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    force_en = 1'b0; force_sel = 2'd0;
`endif
    cyc();
    check("reset_in_ready", {28'd0, rdy4}, 0);
    check("reset_out_valid", {31'd0, ov4}, 0);
    check("reset_out_data", {28'd0, od4}, 0);
    check("reset_out_ch", {30'd0, och4}, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("first_grant_ch0", {28'd0, rdy4}, 32'h1);

    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("rr_ch_%0d", i), {30'd0, och4}, {30'd0, rr_ch[i]});
      check($sformatf("rr_data_%0d", i), {28'd0, od4}, {28'd0, rr_d[i]});
    end

    in_data = 16'hDC5A;
    cyc();
    check("bp_load_word", {28'd0, od4}, 32'h5);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_in_ready_%0d", i), {28'd0, rdy4}, 0);
      check($sformatf("bp_data_%0d", i), {28'd0, od4}, 32'h5);
      check($sformatf("bp_ch_%0d", i), {30'd0, och4}, 32'h1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, rdy4}, 32'h4);
    cyc();
    check("bp_next_ch", {30'd0, och4}, 32'h2);
    check("bp_next_data", {28'd0, od4}, 32'hC);

    in_valid = 4'b0010;
    #1;
    check("wrap_ready", {28'd0, rdy4}, 32'h2);
    cyc();
    check("wrap_ch", {30'd0, och4}, 32'h1);
    in_valid = 4'b0000;
    cyc();
    check("drain_valid", {31'd0, ov4}, 0);
    check("drain_ch_hold", {30'd0, och4}, 32'h1);
    cyc();
    in_valid = 4'hF;
    #1;
    check("ptr_held_ready", {28'd0, rdy4}, 32'h4);
    cyc();
    check("ptr_held_ch", {30'd0, och4}, 32'h2);

`ifdef RR_ARB_MUX_FORCE_SEL_EN
    force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("force_ch_%0d", i), {30'd0, och4}, 32'h2);
    end
    force_en = 1'b0;
    #1;
    check("force_release_ready", {28'd0, rdy4}, 32'h1);
    cyc();
    check("force_release_ch", {30'd0, och4}, 32'h0);
`endif

    rst = 1'b1; in_valid = 4'hF; in_data = 16'hDCBA;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("n3_ch_%0d", i), {30'd0, och3}, {30'd0, n3_ch[i]});
    end
    check("n3_ready_after_wrap", {29'd0, rdy3}, 32'h2);

    for (int i = 0; i < 3000; i++) begin
      cyc();
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 100) == 0;
`ifdef RR_ARB_MUX_FORCE_SEL_EN
      force_en  = ($urandom % 8) == 0;
      force_sel = 2'($urandom);
`endif
    end
    rst = 1'b0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
